// File: rtl/mul_pkg.sv
`default_nettype none
// ============================================================================
// Module : mul_pkg
// Purpose: Shared definitions for the sequential multiplier. Holds the
//          control state encoding and the default operand width.
// Ports  : none (package)
// Rev    : 1.0  initial release
// ============================================================================
package mul_pkg;

    // Default operand / product width for the RV64 datapath.
    localparam int XLEN = 64;

    // Control FSM encoding. The values are fixed so that debug views and
    // any external decode of the state stay stable across revisions.
    typedef enum logic [1:0] {
        MUL_IDLE = 2'b00,
        MUL_RUN  = 2'b01,
        MUL_DONE = 2'b10
    } mul_state_e;

endpackage : mul_pkg
`default_nettype wire

// File: rtl/full_adder.sv
`default_nettype none
// ============================================================================
// Module : full_adder
// Purpose: N-bit unsigned adder with carry out of the top bit.
// Ports  : a        in  N  addend A
//          b        in  N  addend B
//          sum      out N  (a + b) mod 2^N
//          overflow out 1  unsigned carry out of bit N-1
// Rev    : 1.0  initial release
// ============================================================================
module full_adder #(
    parameter int N = 64
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] sum,
    output logic         overflow
);

    // Widen by one bit so the carry lands in the MSB of the result.
    logic [N:0] w_full;

    assign w_full   = {1'b0, a} + {1'b0, b};
    assign sum      = w_full[N-1:0];
    assign overflow = w_full[N];

endmodule : full_adder
`default_nettype wire

// File: rtl/mul_sequencer.sv
`default_nettype none
// ============================================================================
// Module : mul_sequencer
// Purpose: Multi-cycle unsigned shift-and-add multiplier returning the low N
//          bits of A*B plus an overflow flag. One shared adder is stepped
//          once per multiplier bit; iteration stops as soon as the remaining
//          multiplier bits are all zero.
// Ports  : clk          in  1  system clock, rising edge
//          reset        in  1  asynchronous active-high reset
//          start        in  1  request, only honoured in IDLE
//          multiplicand in  N  operand A, captured on accepted start
//          multiplier   in  N  operand B, captured on accepted start
//          busy         out 1  high while in RUN or DONE
//          done         out 1  one-cycle pulse, product/overflow valid
//          product      out N  low N bits of A*B, held until next start
//          overflow     out 1  true product needs more than N bits
// Rev    : 1.0  initial release
// ============================================================================
module mul_sequencer
    import mul_pkg::*;
#(
    parameter int N = XLEN
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] multiplicand,
    input  logic [N-1:0] multiplier,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] product,
    output logic         overflow
);

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    mul_state_e   state_q;
    logic [N-1:0] acc_q;       // running partial product
    logic [N-1:0] mcand_q;     // multiplicand, shifted left each iteration
    logic [N-1:0] mplier_q;    // multiplier, shifted right each iteration
    logic         lost_q;      // a set multiplicand bit has left the top
    logic         ovf_q;       // sticky overflow of the true product
    logic [N-1:0] product_q;
    logic         overflow_q;
    logic         busy_q;
    logic         done_q;

    // ------------------------------------------------------------------------
    // Shared adder: acc + shifted multiplicand
    // ------------------------------------------------------------------------
    logic [N-1:0] w_sum;
    logic         w_carry;

    full_adder #(
        .N (N)
    ) u_full_adder (
        .a        (acc_q),
        .b        (mcand_q),
        .sum      (w_sum),
        .overflow (w_carry)
    );

    // ------------------------------------------------------------------------
    // Next values for one RUN iteration
    // ------------------------------------------------------------------------
    logic [N-1:0] acc_d;
    logic [N-1:0] mcand_d;
    logic [N-1:0] mplier_d;
    logic         lost_d;
    logic         ovf_d;
    logic         mplier_zero;

    assign mplier_zero = (mplier_q == '0);

    always_comb begin
        acc_d    = acc_q;
        ovf_d    = ovf_q;
        // A multiplicand bit that was shifted out earlier only matters once
        // it would have been added in; that is why lost_q feeds ovf only on
        // an add step, using the value from before this shift.
        if (mplier_q[0]) begin
            acc_d = w_sum;
            ovf_d = ovf_q | w_carry | lost_q;
        end
        lost_d   = lost_q | mcand_q[N-1];
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
    end

    // ------------------------------------------------------------------------
    // Control FSM with registered outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= MUL_IDLE;
            acc_q      <= '0;
            mcand_q    <= '0;
            mplier_q   <= '0;
            lost_q     <= 1'b0;
            ovf_q      <= 1'b0;
            product_q  <= '0;
            overflow_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            case (state_q)
                MUL_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        acc_q    <= '0;
                        mcand_q  <= multiplicand;
                        mplier_q <= multiplier;
                        lost_q   <= 1'b0;
                        ovf_q    <= 1'b0;
                        busy_q   <= 1'b1;
                        state_q  <= MUL_RUN;
                    end
                end

                MUL_RUN: begin
                    if (mplier_zero) begin
                        // acc/ovf are final here, so publish them together
                        // with done as the FSM enters DONE.
                        product_q  <= acc_q;
                        overflow_q <= ovf_q;
                        done_q     <= 1'b1;
                        state_q    <= MUL_DONE;
                    end else begin
                        acc_q    <= acc_d;
                        ovf_q    <= ovf_d;
                        lost_q   <= lost_d;
                        mcand_q  <= mcand_d;
                        mplier_q <= mplier_d;
                    end
                end

                MUL_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= MUL_IDLE;
                end

                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= MUL_IDLE;
                end
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign product  = product_q;
    assign overflow = overflow_q;

endmodule : mul_sequencer
`default_nettype wire
